// File: rtl/huffman_pkg.sv
// Shared widths, entry field positions and FSM encoding for the Huffman bit emitter.
package huffman_pkg;

    localparam int unsigned ADDR_W   = 6;
    localparam int unsigned LEN_W    = 4;
    localparam int unsigned CODE_W   = 8;
    localparam int unsigned DATA_W   = 12;

    localparam int unsigned LEN_MSB  = 11;
    localparam int unsigned LEN_LSB  = 8;
    localparam int unsigned CODE_MSB = 7;

    localparam int unsigned MAX_LEN  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FETCH = 2'd2,
        SHIFT = 2'd3
    } state_t;

    // A code length is usable only if it is non-zero and fits the code field.
    function automatic logic len_legal(input logic [LEN_W-1:0] len);
        return (len != '0) && (len <= LEN_W'(MAX_LEN));
    endfunction

endpackage

// File: rtl/huffman_bit_shifter.sv
// Load/shift register and bit down-counter presenting a code MSB-first on a valid/ready stream.
module huffman_bit_shifter
    import huffman_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              load,
    input  logic [CODE_W-1:0] code,
    input  logic [LEN_W-1:0]  len,
    input  logic              bit_ready,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              code_last
);

    logic [CODE_W-1:0] shreg;
    logic [LEN_W-1:0]  cnt;
    logic              valid;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shreg <= '0;
            cnt   <= '0;
            valid <= 1'b0;
        end else if (load) begin
            // Left-justify the right-aligned code so bit 7 is always the next bit out.
            shreg <= code << (LEN_W'(MAX_LEN) - len);
            cnt   <= len;
            valid <= 1'b1;
        end else if (valid && bit_ready) begin
            shreg <= shreg << 1;
            cnt   <= cnt - 1'b1;
            if (cnt == LEN_W'(1)) begin
                valid <= 1'b0;
            end
        end
    end

    assign bit_out   = shreg[CODE_W-1];
    assign bit_valid = valid;
    assign code_last = valid && (cnt == LEN_W'(1));

endmodule

// File: rtl/huffman_bit_emitter.sv
// Looks up each symbol in the Huffman code table and serialises its code MSB-first.
// Optional HUFF_BIT_STATS_EN adds a saturating bit_count of accepted bits.
module huffman_bit_emitter
    import huffman_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] sym_in,
    input  logic              sym_valid,
    output logic              sym_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_modeselect,
    input  logic [DATA_W-1:0] mem_data,
    output logic              bit_out,
    output logic              bit_valid,
    input  logic              bit_ready,
    output logic              code_last,
    output logic              len_err
`ifdef HUFF_BIT_STATS_EN
    ,
    output logic [15:0]       bit_count
`endif
);

    state_t            state;
    state_t            next_state;
    logic [LEN_W-1:0]  entry_len;
    logic [CODE_W-1:0] entry_code;
    logic              entry_ok;
    logic              load;
    logic              last_accept;

    assign entry_len      = mem_data[LEN_MSB:LEN_LSB];
    assign entry_code     = mem_data[CODE_MSB:0];
    assign entry_ok       = len_legal(entry_len);
    assign load           = (state == FETCH) && entry_ok;
    assign last_accept    = code_last && bit_ready;
    assign sym_ready      = (state == IDLE);
    assign mem_modeselect = 1'b0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            mem_addr <= '0;
            len_err  <= 1'b0;
        end else begin
            state   <= next_state;
            len_err <= (state == FETCH) && !entry_ok;
            if ((state == IDLE) && sym_valid) begin
                mem_addr <= sym_in;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (sym_valid) next_state = REQ;
            REQ:     next_state = FETCH;
            FETCH:   next_state = entry_ok ? SHIFT : IDLE;
            SHIFT:   if (last_accept) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    huffman_bit_shifter u_shifter (
        .clock     (clock),
        .reset_n   (reset_n),
        .load      (load),
        .code      (entry_code),
        .len       (entry_len),
        .bit_ready (bit_ready),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .code_last (code_last)
    );

`ifdef HUFF_BIT_STATS_EN
    logic [15:0] stat_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_q <= '0;
        end else if (bit_valid && bit_ready && (stat_q != '1)) begin
            stat_q <= stat_q + 16'd1;
        end
    end

    assign bit_count = stat_q;
`endif

endmodule

// File: tb/tb_huffman_bit_emitter.sv
// Directed bench for huffman_bit_emitter with a behavioural 64x12 registered-address table.
module tb_huffman_bit_emitter;
    import huffman_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [5:0]  sym_in;
    logic        sym_valid;
    logic        sym_ready;
    logic [5:0]  mem_addr;
    logic        mem_modeselect;
    logic [11:0] mem_data;
    logic        bit_out;
    logic        bit_valid;
    logic        bit_ready;
    logic        code_last;
    logic        len_err;
`ifdef HUFF_BIT_STATS_EN
    logic [15:0] bit_count;
`endif

    int unsigned total  = 0;
    int unsigned passed = 0;

    logic [11:0] tbl [64];
    logic [5:0]  addr_q = '0;

    always #5 clock = ~clock;

    // Table registers its address; data follows in the next cycle.
    always @(posedge clock) addr_q <= mem_addr;
    assign mem_data = tbl[addr_q];

    huffman_bit_emitter dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .sym_in         (sym_in),
        .sym_valid      (sym_valid),
        .sym_ready      (sym_ready),
        .mem_addr       (mem_addr),
        .mem_modeselect (mem_modeselect),
        .mem_data       (mem_data),
        .bit_out        (bit_out),
        .bit_valid      (bit_valid),
        .bit_ready      (bit_ready),
        .code_last      (code_last),
        .len_err        (len_err)
`ifdef HUFF_BIT_STATS_EN
        ,
        .bit_count      (bit_count)
`endif
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Returns just after the edge that loads the entry (two cycles after accept).
    task automatic send(input logic [5:0] s);
        chk("sym_ready_idle", 16'(sym_ready), 16'd1);
        sym_in    = s;
        sym_valid = 1'b1;
        tick();
        sym_valid = 1'b0;
        sym_in    = 6'h3F;
        chk("mem_addr", 16'(mem_addr), 16'(s));
        chk("sym_ready_busy", 16'(sym_ready), 16'd0);
        tick();
        chk("bit_valid_fetch", 16'(bit_valid), 16'd0);
        tick();
    endtask

    task automatic expect_code(input int len, input logic [7:0] code);
        for (int i = len - 1; i >= 0; i--) begin
            chk("bit_valid", 16'(bit_valid), 16'd1);
            chk("bit_out", 16'(bit_out), 16'(code[i]));
            chk("code_last", 16'(code_last), 16'(i == 0));
            tick();
        end
        chk("bit_valid_end", 16'(bit_valid), 16'd0);
        chk("sym_ready_end", 16'(sym_ready), 16'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int k;
        logic [7:0] c;

        for (int i = 0; i < 64; i++) tbl[i] = '0;
        tbl[5] = 12'h305;
        tbl[9] = 12'h8A5;
        tbl[7] = 12'h0FF;
        tbl[8] = 12'h9FF;
        tbl[1] = 12'h101;

        reset_n   = 1'b1;
        sym_in    = '0;
        sym_valid = 1'b0;
        bit_ready = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_bit_valid", 16'(bit_valid), 16'd0);
        chk("rst_bit_out", 16'(bit_out), 16'd0);
        chk("rst_code_last", 16'(code_last), 16'd0);
        chk("rst_len_err", 16'(len_err), 16'd0);
        chk("rst_mem_addr", 16'(mem_addr), 16'd0);
        chk("rst_sym_ready", 16'(sym_ready), 16'd1);
        chk("rst_modesel", 16'(mem_modeselect), 16'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Symbol 5: len 3, bits 1,0,1.
        send(6'd5);
        expect_code(3, 8'h05);

        // Symbol 9: len 8 under a stalling ready pattern.
        send(6'd9);
        c   = 8'hA5;
        idx = 0;
        k   = 0;
        while (idx < 8 && k < 40) begin
            bit_ready = ((k % 4) == 0) || ((k % 4) == 3);
            chk("t2_bit_valid", 16'(bit_valid), 16'd1);
            chk("t2_bit_out", 16'(bit_out), 16'(c[7 - idx]));
            chk("t2_code_last", 16'(code_last), 16'(idx == 7));
            tick();
            if (bit_ready) idx++;
            k++;
        end
        chk("t2_transfers", 16'(idx), 16'd8);
        chk("t2_bit_valid_end", 16'(bit_valid), 16'd0);
        chk("t2_modesel", 16'(mem_modeselect), 16'd0);
        bit_ready = 1'b1;

        // Illegal lengths 0 and 9.
        send(6'd7);
        chk("t3_len_err0", 16'(len_err), 16'd1);
        chk("t3_bit_valid0", 16'(bit_valid), 16'd0);
        chk("t3_idle0", 16'(sym_ready), 16'd1);
        tick();
        chk("t3_len_err0_clr", 16'(len_err), 16'd0);
        send(6'd8);
        chk("t3_len_err9", 16'(len_err), 16'd1);
        chk("t3_bit_valid9", 16'(bit_valid), 16'd0);
        tick();
        chk("t3_len_err9_clr", 16'(len_err), 16'd0);
        chk("t3_bit_valid_after", 16'(bit_valid), 16'd0);
        chk("t3_idle9", 16'(sym_ready), 16'd1);

        // Single-bit code.
        send(6'd1);
        expect_code(1, 8'h01);

        // Asynchronous reset mid-code.
        send(6'd9);
        c = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            chk("t5_bit_out", 16'(bit_out), 16'(c[7 - i]));
            tick();
        end
        chk("t5_bit_valid_pre", 16'(bit_valid), 16'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_bit_valid", 16'(bit_valid), 16'd0);
        chk("t5_bit_out", 16'(bit_out), 16'd0);
        chk("t5_code_last", 16'(code_last), 16'd0);
        chk("t5_mem_addr", 16'(mem_addr), 16'd0);
        chk("t5_sym_ready", 16'(sym_ready), 16'd1);
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        chk("t5_bit_valid_rel", 16'(bit_valid), 16'd0);
        send(6'd5);
        expect_code(3, 8'h05);

`ifdef HUFF_BIT_STATS_EN
        reset_n = 1'b0;
        #1;
        chk("st_reset", bit_count, 16'd0);
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        send(6'd5);
        expect_code(3, 8'h05);
        send(6'd9);
        expect_code(8, 8'hA5);
        chk("st_count11", bit_count, 16'd11);
        dut.stat_q = 16'hFFFE;
        send(6'd5);
        expect_code(3, 8'h05);
        chk("st_saturate", bit_count, 16'hFFFF);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
